ifu_fetch: RTL and testbench

Instruction fetch unit directly upstream of the decode/immediate-extend stage. It holds the PC, issues requests to instruction memory over a valid/ready handshake, and buffers one returned instruction. It presents the instruction and its pre-split fields (opcode, rd, funct3, rs1, rs2, funct7) to decode with a valid/ready handshake. It accepts PC redirects from execute, such as branches and jumps.

---
 rtl/ifu_fetch_if.sv | 36 +++
 rtl/ifu_fetch.sv | 135 +++++++++++++
 tb/tb_ifu_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory, redirect and decode-side signals of the fetch unit
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;
    logic        id_err;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, id_opcode,
               id_rd, id_funct3, id_rs1, id_rs2, id_funct7, id_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, id_opcode,
               id_rd, id_funct3, id_rs1, id_rs2, id_funct7, id_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC, single-outstanding imem fetch and one-entry decode buffer; IFU_MISALIGN_CHECK_EN faults misaligned redirects
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master bus
);

    typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        run_q;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_err_q, id_err_d;
    logic        req_vld, hs, take, consume, mis;

`ifdef IFU_MISALIGN_CHECK_EN
    assign mis = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // control registers; run_q holds the request off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            run_q   <= 1'b1;
        end
    end

    // next state; drop marks the outstanding response as stale after a redirect
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            REQ: begin
                if (hs) begin
                    state_d = WAIT;
                    drop_d  = bus.redirect_valid;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = take ? HOLD : REQ;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = drop_q | bus.redirect_valid;
                end
            end
            HOLD: begin
                if (consume | bus.redirect_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
`ifdef IFU_MISALIGN_CHECK_EN
        if (state_q != WAIT && bus.imem_rsp_valid) drop_d = 1'b0;
        if (mis) begin
            state_d = HOLD;
            drop_d  = hs | (((state_q == WAIT) | drop_q) & ~bus.imem_rsp_valid);
        end
`endif
        pc_d = bus.redirect_valid ? bus.redirect_pc : consume ? pc_q + PC_STEP : pc_q;
    end

    // handshake decodes; no new request while a stale response is still owed
    always_comb begin
        req_vld = (state_q == REQ) & run_q & ~drop_q;
        hs      = req_vld & bus.imem_req_ready;
        take    = (state_q == WAIT) & bus.imem_rsp_valid & ~drop_q & ~bus.redirect_valid;
        consume = id_valid_q & bus.id_ready;
    end

    // buffer next value; faulting fetches deliver a zero instruction word
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_err_d   = id_err_q;
        if (mis) begin
            id_valid_d = 1'b1;
            id_pc_d    = bus.redirect_pc;
            id_inst_d  = 32'h0;
            id_err_d   = 1'b1;
        end else if (take) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
            id_err_d   = bus.imem_rsp_err;
        end else if (consume | bus.redirect_valid) begin
            id_valid_d = 1'b0;
        end
    end

    // decode buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
            id_err_q   <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_err_q   <= id_err_d;
        end
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_err         = id_err_q;
    assign bus.id_opcode      = id_inst_q[6:0];
    assign bus.id_rd          = id_inst_q[11:7];
    assign bus.id_funct3      = id_inst_q[14:12];
    assign bus.id_rs1         = id_inst_q[19:15];
    assign bus.id_rs2         = id_inst_q[24:20];
    assign bus.id_funct7      = id_inst_q[31:25];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: random traffic against a transaction-level fetch model
module tb_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ifu_fetch_if bus ();

    ifu_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_pc, m_bpc, m_binst;
    bit          m_run, m_bv, m_berr;
    bit          m_q[$];
    int          dly[$];
    int          hold;
    bit          rv_real;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_run = 0;
        m_bv = 0;
        m_bpc = 0;
        m_binst = 0;
        m_berr = 0;
        m_q.delete();
    endtask

    task automatic check_all();
        bit ev;
        ev = m_run && m_q.size() == 0 && !m_bv;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(ev));
        if (ev) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("id_valid", 32'(bus.id_valid), 32'(m_bv));
        chk("id_pc", bus.id_pc, m_bpc);
        chk("id_inst", bus.id_inst, m_binst);
        chk("id_err", 32'(bus.id_err), 32'(m_berr));
        chk("opcode", 32'(bus.id_opcode), 32'(m_binst[6:0]));
        chk("rd", 32'(bus.id_rd), 32'(m_binst[11:7]));
        chk("funct3", 32'(bus.id_funct3), 32'(m_binst[14:12]));
        chk("rs1", 32'(bus.id_rs1), 32'(m_binst[19:15]));
        chk("rs2", 32'(bus.id_rs2), 32'(m_binst[24:20]));
        chk("funct7", 32'(bus.id_funct7), 32'(m_binst[31:25]));
    endtask

    task automatic model_step();
        bit ev, hs, cons, rd, mis, pre, w;
        ev   = m_run && m_q.size() == 0 && !m_bv;
        hs   = ev && bus.imem_req_ready;
        cons = m_bv && bus.id_ready;
        rd   = bus.redirect_valid;
        mis  = 0;
`ifdef IFU_MISALIGN_CHECK_EN
        mis  = rd && bus.redirect_pc[1:0] != 2'b00;
`endif
        pre = m_bv;
        if (cons || rd) m_bv = 0;
        if (bus.imem_rsp_valid && m_q.size() > 0) begin
            w = m_q.pop_front();
            if (w && !rd && !pre) begin
                m_bv = 1;
                m_bpc = m_pc;
                m_berr = bus.imem_rsp_err;
                m_binst = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
            end
        end
        if (rd) foreach (m_q[i]) m_q[i] = 0;
        if (hs) m_q.push_back(!rd);
        if (mis) begin
            m_bv = 1;
            m_bpc = bus.redirect_pc;
            m_binst = 0;
            m_berr = 1;
        end
        m_pc = rd ? bus.redirect_pc : cons ? m_pc + 32'd4 : m_pc;
        m_run = 1;
    endtask

    task automatic drive();
        int r;
        rv_real = dly.size() > 0 && dly[0] == 0;
        bus.imem_rsp_valid = rv_real || (dly.size() == 0 && $urandom_range(0, 7) == 0);
        bus.imem_rsp_data  = $urandom;
        bus.imem_rsp_err   = $urandom_range(0, 7) == 0;
        bus.imem_req_ready = hold > 0 ? 1'b0 : $urandom_range(0, 3) != 0;
        bus.id_ready       = $urandom_range(0, 3) != 0;
        bus.redirect_valid = $urandom_range(0, 7) == 0;
        r = $urandom_range(0, 3);
        bus.redirect_pc = r == 0 ? 32'hFFFF_FFFC :
                          r == 1 ? RST_PC + {24'h0, 6'($urandom), 2'b00} :
                          r == 2 ? RST_PC + {24'h0, 8'($urandom)} :
                                   ($urandom & 32'hFFFF_FFFC);
        if (hold > 0) hold--;
    endtask

    task automatic responder_step();
        if (rv_real) void'(dly.pop_front());
        else if (dly.size() > 0 && dly[0] > 0) dly[0]--;
        if (bus.imem_req_valid && bus.imem_req_ready) dly.push_back($urandom_range(0, 3));
    endtask

    initial begin
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        bus.imem_rsp_err   = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc    = 0;
        bus.id_ready       = 0;
        hold = 0;
        rv_real = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
                hold = 6;
            end
            drive();
            #1;
            check_all();
            model_step();
            responder_step();
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
